// File: rtl/eth_pkg.sv
// eth_pkg -- shared constants and scheduler state encoding for the eth_tx path.
//   ETH_ADR_W           : width of a frame byte count / buffer address
//   PAKET_MAX_SIZE_DEF  : default largest legal frame in bytes (must match the engine)
//   IFG_CLKS_DEF        : default inter-frame gap in clocks (96 bit times at 2 bits/clk)
//   START_TMO_DEF       : default clocks allowed for the engine to acknowledge a start
//   sched_state_t       : eth_tx_sched state encoding
package eth_pkg;

  localparam int ETH_ADR_W = 11;
  localparam logic [ETH_ADR_W-1:0] PAKET_MAX_SIZE_DEF = 11'd1500;
  localparam int IFG_CLKS_DEF = 48;
  localparam int START_TMO_DEF = 15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    IFG
  } sched_state_t;

  // A frame is legal when it carries at least one byte and fits the buffer.
  function automatic logic size_legal(input logic [ETH_ADR_W-1:0] size,
                                      input logic [ETH_ADR_W-1:0] max_size);
    return (size != '0) && (size <= max_size);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- round-robin pick among N requesters.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   req          : request vector
//   en           : accept the current pick; the pointer moves to the winner
//   gnt          : one-hot winner (combinational), all zero when req is zero
//   idx          : binary index of the winner (combinational)
// The search starts one past the last accepted winner, so the most recent
// owner always has the lowest priority on the next pick.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_reg;
  logic [IW:0]   cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // (ptr + 1 + i) mod N; one subtraction suffices since the sum is < 2N
      cand = {1'b0, ptr_reg} + (IW+1)'(i + 1);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
    if (found) begin
      gnt[idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_reg <= '0;
    end else if (en && found) begin
      ptr_reg <= idx;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// eth_tx_sched -- shares one 2-bit RMII-style eth_tx frame engine between
// N_REQ requesters, each owning a frame buffer bank.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_req        : per-requester level request, held until o_done/o_err
//   i_size       : per-requester byte count, slice k = [11k+10:11k]
//   o_grant      : one-hot current owner, or zero
//   o_sel        : binary index of the granted bank (external RAM mux select)
//   o_done       : one-clock pulse per completed frame
//   o_err        : one-clock pulse per rejected or timed-out frame
//   o_tx_en      : one-clock start strobe to the engine
//   i_tx_ready   : engine ready, high while idle
//   o_tx_size    : frame byte count to the engine, stable for the whole frame
//   o_busy       : high in every state except IDLE
// Optional build macro ETH_TX_SCHED_STATS_EN adds saturating counters
//   o_frame_cnt (16 bit, completed frames) and o_err_cnt (8 bit, errors).
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int                   N_REQ          = 4,
  parameter logic [ETH_ADR_W-1:0] PAKET_MAX_SIZE = PAKET_MAX_SIZE_DEF,
  parameter int                   IFG_CLKS       = IFG_CLKS_DEF,
  parameter int                   START_TMO      = START_TMO_DEF,
  localparam int                  SW             = $clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*ETH_ADR_W-1:0] i_size,
  output logic [N_REQ-1:0]          o_grant,
  output logic [SW-1:0]             o_sel,
  output logic [N_REQ-1:0]          o_done,
  output logic [N_REQ-1:0]          o_err,
  output logic                      o_tx_en,
  input  logic                      i_tx_ready,
  output logic [ETH_ADR_W-1:0]      o_tx_size,
`ifdef ETH_TX_SCHED_STATS_EN
  output logic [15:0]               o_frame_cnt,
  output logic [7:0]                o_err_cnt,
`endif
  output logic                      o_busy
);

  // One counter serves both the start timeout and the inter-frame gap.
  localparam int CW = $clog2(((IFG_CLKS > START_TMO) ? IFG_CLKS : START_TMO) + 1);

  sched_state_t         state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [ETH_ADR_W-1:0] size_arr [N_REQ];
  logic [N_REQ-1:0]     arb_gnt;
  logic [SW-1:0]        arb_idx;
  logic                 arb_en;
  logic [ETH_ADR_W-1:0] win_size;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_size
    assign size_arr[gi] = i_size[ETH_ADR_W*gi +: ETH_ADR_W];
  end

  // A grant still showing in IDLE is the tail of a rejection; it must clear
  // before the next pick so the rejected requester can drop its request.
  // The engine has no reset, so nothing is granted until it reports ready.
  assign arb_en   = (state_reg == IDLE) && (o_grant == '0) && (|i_req) && i_tx_ready;
  assign win_size = size_arr[arb_idx];

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .req   (i_req),
    .en    (arb_en),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      o_grant   <= '0;
      o_sel     <= '0;
      o_done    <= '0;
      o_err     <= '0;
      o_tx_en   <= 1'b0;
      o_tx_size <= '0;
      o_busy    <= 1'b0;
    end else begin
      o_tx_en <= 1'b0;
      o_done  <= '0;
      o_err   <= '0;
      case (state_reg)
        IDLE: begin
          if (o_grant != '0) begin
            o_grant <= '0;
          end else if (arb_en) begin
            o_grant   <= arb_gnt;
            o_sel     <= arb_idx;
            o_tx_size <= win_size;
            // The engine silently drops oversize starts, so bad sizes are
            // rejected here and the engine is never started.
            if (!size_legal(win_size, PAKET_MAX_SIZE)) begin
              o_err <= arb_gnt;
            end else begin
              state_reg <= START;
              o_busy    <= 1'b1;
            end
          end
        end
        START: begin
          o_tx_en   <= 1'b1;
          cnt_reg   <= CW'(START_TMO);
          state_reg <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!i_tx_ready) begin
            state_reg <= WAIT_DONE;
          end else if (cnt_reg == '0) begin
            o_err     <= o_grant;
            o_grant   <= '0;
            cnt_reg   <= CW'(IFG_CLKS - 1);
            state_reg <= IFG;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        WAIT_DONE: begin
          // o_tx_size/o_sel stay untouched: the engine compares the size
          // against its read address on every byte.
          if (i_tx_ready) begin
            o_done    <= o_grant;
            o_grant   <= '0;
            cnt_reg   <= CW'(IFG_CLKS - 1);
            state_reg <= IFG;
          end
        end
        IFG: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            o_busy    <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ETH_TX_SCHED_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      if ((|o_done) && (o_frame_cnt != '1)) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
      if ((|o_err) && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched -- directed bench for eth_tx_sched with a simple engine
// model: ready drops one clock after o_tx_en and returns eng_len clocks
// later; with eng_hang set the model ignores starts entirely.
module tb_eth_tx_sched;
  import eth_pkg::*;

  localparam int N = 4;
  localparam int GAP = IFG_CLKS_DEF + 2;
  localparam int TMO_LAT = START_TMO_DEF + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*11-1:0] size;
  logic [N-1:0]   grant, done, err;
  logic [1:0]     sel;
  logic           tx_en;
  logic [10:0]    tx_size;
  logic           busy;
  logic           tx_ready = 1'b1;
`ifdef ETH_TX_SCHED_STATS_EN
  logic [15:0]    frame_cnt;
  logic [7:0]     err_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // engine model state
  int   eng_len = 500;
  bit   eng_hang = 1'b0;
  bit   eng_busy = 1'b0;
  int   eng_cnt = 0;

  always #5 clk = ~clk;

  eth_tx_sched #(.N_REQ(N)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_size     (size),
    .o_grant    (grant),
    .o_sel      (sel),
    .o_done     (done),
    .o_err      (err),
    .o_tx_en    (tx_en),
    .i_tx_ready (tx_ready),
    .o_tx_size  (tx_size),
`ifdef ETH_TX_SCHED_STATS_EN
    .o_frame_cnt(frame_cnt),
    .o_err_cnt  (err_cnt),
`endif
    .o_busy     (busy)
  );

  always @(posedge clk) begin
    if (eng_busy) begin
      if (eng_cnt == 0) begin
        tx_ready <= 1'b1;
        eng_busy <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (tx_en && !eng_hang) begin
      tx_ready <= 1'b0;
      eng_busy <= 1'b1;
      eng_cnt  <= eng_len - 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // kind: 0 tx_en, 1 any done, 2 any err, 3 busy low
  task automatic wait_event(input int kind, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((kind == 0 && tx_en) || (kind == 1 && done != '0) ||
          (kind == 2 && err != '0) || (kind == 3 && !busy)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; size = '0;
    tick(); tick();
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    total++; if ({done, err} !== 8'h00) begin bad++; $display("FAIL reset_done_err: got %h want 00", {done, err}); end
    total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    total++; if (tx_size !== 11'd0) begin bad++; $display("FAIL reset_tx_size: got %0d want 0", tx_size); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick();
    total++; if ({grant, busy} !== 5'b0) begin bad++; $display("FAIL idle_no_req: got %b want 00000", {grant, busy}); end
  endtask

  task automatic test_single();
    int t_en, t_done, pulses;
    bit hold_bad, ok;
    eng_len = 500;
    req = 4'b0001; size[10:0] = 11'd64;
    tick();
    total++; if ({grant, tx_en} !== 5'b00010) begin bad++; $display("FAIL single_latch: got %b want 00010", {grant, tx_en}); end
    tick();
    total++; if (tx_en !== 1'b1) begin bad++; $display("FAIL single_tx_en_lat: got %b want 1", tx_en); end
    t_en = cyc; pulses = 1; hold_bad = 1'b0;
    req = 4'b0000;   // dropped mid-frame, the frame must still finish
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (tx_en) pulses++;
      if (done != '0) begin ok = 1'b1; break; end
      if (grant !== 4'b0001 || tx_size !== 11'd64 || sel !== 2'd0) hold_bad = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL single_done_seen: got timeout want done"); end
    t_done = cyc;
    total++; if (pulses != 1) begin bad++; $display("FAIL single_tx_en_count: got %0d want 1", pulses); end
    total++; if (hold_bad) begin bad++; $display("FAIL single_hold: got changed want stable grant/size/sel"); end
    total++; if ({done, err} !== 8'h10) begin bad++; $display("FAIL single_done: got %h want 10", {done, err}); end
    total++; if (t_done - t_en != 502) begin bad++; $display("FAIL single_frame_len: got %0d want 502", t_done - t_en); end
    $display("frame k=0 size=64 done at cyc %0d", t_done);
    wait_event(3, 100, ok);
    total++; if (!ok || cyc - t_done != IFG_CLKS_DEF) begin bad++; $display("FAIL single_busy_low: got %0d want %0d", cyc - t_done, IFG_CLKS_DEF); end
  endtask

  task automatic test_all_four();
    int order[4] = '{1, 2, 3, 0};
    int t_done;
    logic [3:0] exp_g;
    bit ok;
    eng_len = 100;
    size = {11'd63, 11'd62, 11'd61, 11'd60};
    req = 4'b1111;
    t_done = 0;
    for (int f = 0; f < 4; f++) begin
      exp_g = 4'b0001 << order[f];
      wait_event(0, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL four_tx_en_%0d: got timeout want tx_en", f); end
      total++; if (grant !== exp_g || tx_size !== 11'(60 + order[f])) begin
        bad++; $display("FAIL four_grant_%0d: got %b/%0d want %b/%0d", f, grant, tx_size, exp_g, 60 + order[f]); end
      if (f > 0) begin
        total++; if (cyc - t_done != GAP) begin bad++; $display("FAIL four_gap_%0d: got %0d want %0d", f, cyc - t_done, GAP); end
      end
      wait_event(1, 300, ok);
      total++; if (!ok || done !== exp_g) begin bad++; $display("FAIL four_done_%0d: got %b want %b", f, done, exp_g); end
      t_done = cyc;
      req[order[f]] = 1'b0;
      $display("frame k=%0d size=%0d done at cyc %0d", order[f], 60 + order[f], t_done);
    end
    wait_event(3, 100, ok);
  endtask

  task automatic test_reject();
    bit en_seen, ok;
    en_seen = 1'b0;
    eng_len = 40;
    size[32:22] = 11'd1501; req = 4'b0100;
    tick(); en_seen |= tx_en;
    total++; if ({grant, err, sel} !== 10'b0100_0100_10) begin bad++; $display("FAIL rej_big: got %b want 0100010010", {grant, err, sel}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_big_busy: got %b want 0", busy); end
    req = 4'b0000;
    tick(); en_seen |= tx_en;
    total++; if ({grant, err} !== 8'h00) begin bad++; $display("FAIL rej_clear: got %h want 00", {grant, err}); end
    size[32:22] = 11'd0; req = 4'b0100;
    tick(); en_seen |= tx_en;
    total++; if ({err, done} !== 8'h40) begin bad++; $display("FAIL rej_zero: got %h want 40", {err, done}); end
    req = 4'b0000;
    tick(); en_seen |= tx_en;
    tick(); en_seen |= tx_en;
    total++; if (en_seen) begin bad++; $display("FAIL rej_tx_en: got 1 want 0"); end
    $display("rejects k=2 sizes 1501,0");
    // pointer now at 2: requester 3 goes ahead of requester 1
    size[21:11] = 11'd70; size[43:33] = 11'd71; req = 4'b1010;
    wait_event(0, 20, ok);
    total++; if (!ok || sel !== 2'd3) begin bad++; $display("FAIL rej_ptr_first: got %0d want 3", sel); end
    wait_event(1, 200, ok);
    req[3] = 1'b0;
    wait_event(0, 200, ok);
    total++; if (!ok || sel !== 2'd1) begin bad++; $display("FAIL rej_ptr_second: got %0d want 1", sel); end
    wait_event(1, 200, ok);
    total++; if (!ok || done !== 4'b0010) begin bad++; $display("FAIL rej_ptr_done: got %b want 0010", done); end
    req = 4'b0000;
    wait_event(3, 100, ok);
  endtask

  task automatic test_timeout();
    int t_en, t_err;
    bit ok;
    eng_hang = 1'b1;
    size[32:22] = 11'd100; req = 4'b0100;
    wait_event(0, 20, ok);
    t_en = cyc;
    wait_event(2, 40, ok);
    total++; if (!ok || cyc - t_en != TMO_LAT) begin bad++; $display("FAIL tmo_latency: got %0d want %0d", cyc - t_en, TMO_LAT); end
    total++; if ({err, done, grant} !== 12'h400 || busy !== 1'b1) begin bad++; $display("FAIL tmo_err: got %h/%b want 400/1", {err, done, grant}, busy); end
    t_err = cyc;
    $display("timeout k=2 at cyc %0d", t_err);
    eng_hang = 1'b0;
    size[10:0] = 11'd90; req = 4'b0001;
    wait_event(0, 100, ok);
    total++; if (!ok || cyc - t_err != GAP || sel !== 2'd0) begin bad++; $display("FAIL tmo_next: got %0d/%0d want %0d/0", cyc - t_err, sel, GAP); end
    wait_event(1, 200, ok);
    total++; if (!ok || done !== 4'b0001) begin bad++; $display("FAIL tmo_next_done: got %b want 0001", done); end
    req = 4'b0000;
    wait_event(3, 100, ok);
  endtask

  task automatic test_rst_mid();
    int t_ready, n;
    bit grant_bad, ok;
    eng_len = 500;
    size[21:11] = 11'd80; req = 4'b0010;
    wait_event(0, 20, ok);
    for (int i = 0; i < 10; i++) tick();
    total++; if ({busy, tx_ready} !== 2'b10) begin bad++; $display("FAIL rst_pre: got %b want 10", {busy, tx_ready}); end
    rst = 1'b1;
    #1;
    total++; if ({grant, sel, done, err, tx_en, tx_size, busy} !== 27'd0) begin
      bad++; $display("FAIL rst_async: got %h want 0", {grant, sel, done, err, tx_en, tx_size, busy}); end
    tick();
    rst = 1'b0;
    grant_bad = 1'b0; n = 0;
    while (tx_ready == 1'b0 && n < 700) begin
      if (grant != '0) grant_bad = 1'b1;
      tick(); n++;
    end
    total++; if (grant_bad || grant !== 4'b0 || tx_ready !== 1'b1) begin bad++; $display("FAIL rst_no_grant: got %b/%b want 0000/1", grant, tx_ready); end
    t_ready = cyc;
    wait_event(0, 10, ok);
    total++; if (!ok || cyc - t_ready != 2 || sel !== 2'd1 || tx_size !== 11'd80) begin
      bad++; $display("FAIL rst_restart: got %0d/%0d/%0d want 2/1/80", cyc - t_ready, sel, tx_size); end
    wait_event(1, 700, ok);
    total++; if (!ok || done !== 4'b0010) begin bad++; $display("FAIL rst_done: got %b want 0010", done); end
    $display("frame k=1 size=80 after reset done at cyc %0d", cyc);
    req = 4'b0000;
    wait_event(3, 100, ok);
  endtask

`ifdef ETH_TX_SCHED_STATS_EN
  task automatic test_stats();
    bit ok;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    total++; if ({frame_cnt, err_cnt} !== 24'd0) begin bad++; $display("FAIL stats_reset: got %h want 0", {frame_cnt, err_cnt}); end
    eng_len = 20;
    for (int i = 0; i < 3; i++) begin
      size[10:0] = 11'd64; req = 4'b0001;
      wait_event(1, 200, ok);
      req = 4'b0000;
      wait_event(3, 100, ok);
    end
    for (int i = 0; i < 2; i++) begin
      size[10:0] = 11'd0; req = 4'b0001; tick(); req = 4'b0000; tick();
    end
    tick();
    total++; if (frame_cnt !== 16'd3 || err_cnt !== 8'd2) begin bad++; $display("FAIL stats_counts: got %0d/%0d want 3/2", frame_cnt, err_cnt); end
    for (int i = 0; i < 300; i++) begin
      size[10:0] = 11'd1600; req = 4'b0001; tick(); req = 4'b0000; tick();
    end
    tick();
    total++; if (err_cnt !== 8'd255 || frame_cnt !== 16'd3) begin bad++; $display("FAIL stats_sat: got %0d/%0d want 255/3", err_cnt, frame_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_reject();
    test_timeout();
    test_rst_mid();
`ifdef ETH_TX_SCHED_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
